// File: rtl/sram_pkg.sv
// Shared constants for the bus-to-SRAM responder: FSM state encoding and
// the layout of the 36-bit command word.
package sram_pkg;

    localparam int SRAM_ADDR_W = 19;
    localparam int SRAM_DATA_W = 16;

    localparam int CMD_RW       = 35;
    localparam int CMD_DATA_MSB = 34;
    localparam int CMD_DATA_LSB = 19;
    localparam int CMD_ADDR_MSB = 18;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_e;

endpackage

// File: rtl/sram_dq_buf.sv
// SRAM data-pin buffer: tri-state write driver and the read-capture
// register that feeds miso.
module sram_dq_buf #(
    parameter int DATA_W = 16
) (
    input  logic              sck,
    input  logic              rst_n,
    input  logic              drv_en,
    input  logic [DATA_W-1:0] wdata,
    input  logic              cap_en,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic [DATA_W-1:0] miso
);

    logic [DATA_W-1:0] miso_q;

    assign sram_data = drv_en ? wdata : {DATA_W{1'bz}};

    // Holds the last read word; writes never touch it.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            miso_q <= '0;
        end else if (cap_en) begin
            miso_q <= sram_data;
        end
    end

    assign miso = miso_q;

endmodule

// File: rtl/sram_resp_ctrl.sv
// Executes one bus command at a time as a timed access on an asynchronous
// 16-bit SRAM: IDLE -> SETUP -> ACCESS (WAIT_CYC cycles) -> HOLD -> IDLE.
module sram_resp_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int DATA_W   = SRAM_DATA_W,
    parameter int WAIT_CYC = 1
) (
    input  logic                     sck,
    input  logic                     rst_n,
    input  logic                     cs_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDR_W+DATA_W:0]   mosi,
    output logic [DATA_W-1:0]        miso,
    output logic                     rsp_valid,
    output logic                     busy,
    output logic [ADDR_W-1:0]        sram_addr,
    inout  wire  [DATA_W-1:0]        sram_data,
    output logic                     sram_oe_n,
    output logic                     sram_ce_n,
    output logic                     sram_we_n,
    output logic                     sram_ub,
    output logic                     sram_lb
);

    localparam int          RW_BIT   = ADDR_W + DATA_W;
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYC - 1);

    state_e              state_q, state_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          cnt_q, cnt_d;

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && !cs_n) begin
                    rw_d    = mosi[RW_BIT];
                    wdata_d = mosi[RW_BIT-1:ADDR_W];
                    addr_d  = mosi[ADDR_W-1:0];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_INIT;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes decode straight from the state register so an async reset
    // releases the SRAM pins without waiting for a clock edge.
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == HOLD);
    assign sram_ce_n = (state_q == IDLE);
    assign sram_ub   = (state_q == IDLE);
    assign sram_lb   = (state_q == IDLE);
    assign sram_we_n = !((state_q == ACCESS) && rw_q);
    assign sram_oe_n = !((state_q == ACCESS) && !rw_q);
    assign sram_addr = addr_q;

    sram_dq_buf #(
        .DATA_W (DATA_W)
    ) u_dq_buf (
        .sck       (sck),
        .rst_n     (rst_n),
        .drv_en    (rw_q && (state_q != IDLE)),
        .wdata     (wdata_q),
        .cap_en    ((state_q == ACCESS) && !rw_q && (cnt_q == 4'd0)),
        .sram_data (sram_data),
        .miso      (miso)
    );

endmodule

// File: tb/tb_sram_resp_ctrl.sv
// Directed bench for sram_resp_ctrl: instance A (WAIT_CYC=1) and B (WAIT_CYC=3),
// each with a small behavioural SRAM on a pulled-up data bus.
module tb_sram_resp_ctrl;
    import sram_pkg::*;

    localparam int WAIT_A = 1;
    localparam int WAIT_B = 3;

    logic        sck = 1'b0;
    logic        rst_n = 1'b0;

    logic        cs_n_a = 1'b1, cmd_valid_a = 1'b0;
    logic [35:0] mosi_a = '0;
    logic        cmd_ready_a, rsp_valid_a, busy_a;
    logic [15:0] miso_a;
    logic [18:0] addr_a;
    logic        oe_n_a, ce_n_a, we_n_a, ub_a, lb_a;
    wire  [15:0] dq_a;

    logic        cs_n_b = 1'b1, cmd_valid_b = 1'b0;
    logic [35:0] mosi_b = '0;
    logic        cmd_ready_b, rsp_valid_b, busy_b;
    logic [15:0] miso_b;
    logic [18:0] addr_b;
    logic        oe_n_b, ce_n_b, we_n_b, ub_b, lb_b;
    wire  [15:0] dq_b;

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];

    int n_chk = 0;
    int n_err = 0;
    int n_tovr = 0;

    always #5 sck = ~sck;

    sram_resp_ctrl #(.WAIT_CYC(WAIT_A)) dut_a (
        .sck(sck), .rst_n(rst_n), .cs_n(cs_n_a), .cmd_valid(cmd_valid_a),
        .cmd_ready(cmd_ready_a), .mosi(mosi_a), .miso(miso_a),
        .rsp_valid(rsp_valid_a), .busy(busy_a), .sram_addr(addr_a),
        .sram_data(dq_a), .sram_oe_n(oe_n_a), .sram_ce_n(ce_n_a),
        .sram_we_n(we_n_a), .sram_ub(ub_a), .sram_lb(lb_a)
    );

    sram_resp_ctrl #(.WAIT_CYC(WAIT_B)) dut_b (
        .sck(sck), .rst_n(rst_n), .cs_n(cs_n_b), .cmd_valid(cmd_valid_b),
        .cmd_ready(cmd_ready_b), .mosi(mosi_b), .miso(miso_b),
        .rsp_valid(rsp_valid_b), .busy(busy_b), .sram_addr(addr_b),
        .sram_data(dq_b), .sram_oe_n(oe_n_b), .sram_ce_n(ce_n_b),
        .sram_we_n(we_n_b), .sram_ub(ub_b), .sram_lb(lb_b)
    );

    // Undriven bus reads as all ones, so a released bus is visible as 16'hFFFF.
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (dq_a[i]);
        pullup (dq_b[i]);
    end

    assign dq_a = (!ce_n_a && !oe_n_a) ? mem_a[addr_a[7:0]] : 16'hzzzz;
    assign dq_b = (!ce_n_b && !oe_n_b) ? mem_b[addr_b[7:0]] : 16'hzzzz;

    always @(posedge sck) begin
        if (!ce_n_a && !we_n_a) mem_a[addr_a[7:0]] <= dq_a;
        if (!ce_n_b && !we_n_b) mem_b[addr_b[7:0]] <= dq_b;
    end

    // Any controller drive while the SRAM outputs shows up as a corrupted read word.
    always @(negedge sck) begin
        if (!ce_n_a && !oe_n_a && (dq_a !== mem_a[addr_a[7:0]])) n_tovr = n_tovr + 1;
        if (!we_n_a && !oe_n_a) n_tovr = n_tovr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One access on instance A; returns the rsp cycle (edges after accept),
    // pulse count, strobe-low counts, miso in the rsp cycle and pin violations.
    task automatic acc_a(input logic rw, input logic [15:0] d, input logic [18:0] a,
                         input bit cs_drop, output int rsp_k, output int nrsp,
                         output int we_lo, output int oe_lo, output logic [15:0] m_rsp,
                         output int bad);
        int to;
        @(negedge sck);
        cs_n_a = 1'b0;
        cmd_valid_a = 1'b1;
        mosi_a = {rw, d, a};
        to = 0;
        while (!cmd_ready_a && to < 20) begin
            @(negedge sck);
            to++;
        end
        chk("accept_timeout", 32'(to < 20), 32'd1);
        @(posedge sck);
        #1;
        cmd_valid_a = 1'b0;
        mosi_a = '1;
        rsp_k = 0; nrsp = 0; we_lo = 0; oe_lo = 0; bad = 0; m_rsp = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge sck);
            if (k == 1 && cs_drop) cs_n_a = 1'b1;
            if (rsp_valid_a) begin
                nrsp++;
                if (rsp_k == 0) begin rsp_k = k; m_rsp = miso_a; end
            end
            if (!we_n_a) we_lo++;
            if (!oe_n_a) oe_lo++;
            if (k <= 2 + WAIT_A) begin
                if (ce_n_a !== 1'b0 || busy_a !== 1'b1 || cmd_ready_a !== 1'b0 ||
                    addr_a !== a || ub_a !== 1'b0 || lb_a !== 1'b0) bad++;
                if (rw && dq_a !== d) bad++;
                if (!rw && oe_n_a && dq_a !== 16'hFFFF) bad++;
            end else begin
                if (ce_n_a !== 1'b1 || busy_a !== 1'b0 || cmd_ready_a !== 1'b1 ||
                    ub_a !== 1'b1 || dq_a !== 16'hFFFF) bad++;
            end
        end
        cs_n_a = 1'b1;
    endtask

    initial begin
        int rk, nr, wl, ol, bd, t1, t2, acc, rlo, n;
        logic [15:0] m;

        mem_a[8'h20] <= 16'hA5A5;
        mem_b[8'hFF] <= 16'h1234;

        // Reset state
        #2;
        chk("rst_ce_n", 32'(ce_n_a), 32'd1);
        chk("rst_strobes", 32'({oe_n_a, we_n_a, ub_a, lb_a}), 32'hF);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_dq_z", 32'(dq_a), 32'hFFFF);
        chk("rst_outs", 32'({miso_a, rsp_valid_a, busy_a}), 32'd0);
        #10 rst_n = 1'b1;
        @(negedge sck);
        chk("rst_ready", 32'({cmd_ready_a, cmd_ready_b}), 32'h3);

        // Write then read, WAIT_CYC=1
        acc_a(1'b1, 16'hBEEF, 19'h00010, 1'b0, rk, nr, wl, ol, m, bd);
        chk("wr_rsp_lat", 32'(rk), 32'd3);
        chk("wr_rsp_cnt", 32'(nr), 32'd1);
        chk("wr_we_lo", 32'(wl), 32'd1);
        chk("wr_oe_lo", 32'(ol), 32'd0);
        chk("wr_pins", 32'(bd), 32'd0);
        acc_a(1'b0, 16'h0000, 19'h00010, 1'b0, rk, nr, wl, ol, m, bd);
        chk("rd_rsp_lat", 32'(rk), 32'd3);
        chk("rd_oe_lo", 32'(ol), 32'd1);
        chk("rd_we_lo", 32'(wl), 32'd0);
        chk("rd_miso_at_rsp", 32'(m), 32'hBEEF);
        chk("rd_pins", 32'(bd), 32'd0);
        acc_a(1'b1, 16'h1111, 19'h00040, 1'b0, rk, nr, wl, ol, m, bd);
        chk("miso_kept_by_wr", 32'(miso_a), 32'hBEEF);

        // WAIT_CYC=3, read of top address
        @(negedge sck);
        cs_n_b = 1'b0;
        cmd_valid_b = 1'b1;
        mosi_b = {1'b0, 16'h0000, 19'h7FFFF};
        @(posedge sck);
        #1;
        cmd_valid_b = 1'b0;
        mosi_b = '0;
        rk = 0; ol = 0; bd = 0; m = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge sck);
            if (!oe_n_b) ol++;
            if (rsp_valid_b && rk == 0) begin rk = k; m = miso_b; end
            if (!ce_n_b && addr_b !== 19'h7FFFF) bd++;
        end
        cs_n_b = 1'b1;
        chk("b_oe_lo", 32'(ol), 32'd3);
        chk("b_rsp_lat", 32'(rk), 32'd5);
        chk("b_miso", 32'(m), 32'h1234);
        chk("b_addr", 32'(bd), 32'd0);

        // Back-to-back with cmd_valid held high
        @(negedge sck);
        cs_n_a = 1'b0;
        cmd_valid_a = 1'b1;
        mosi_a = {1'b1, 16'h5A5A, 19'h00030};
        t1 = -1; t2 = -1; acc = 0; rlo = 0;
        for (int c = 0; c < 20; c++) begin
            if (cmd_ready_a && cmd_valid_a) begin
                if (acc == 0) t1 = c; else t2 = c;
                acc++;
            end else if (acc == 1 && !cmd_ready_a) begin
                rlo++;
            end
            @(posedge sck);
            #1;
            if (acc == 1) mosi_a = {1'b0, 16'h0000, 19'h00030};
            if (acc == 2) cmd_valid_a = 1'b0;
            @(negedge sck);
        end
        cs_n_a = 1'b1;
        chk("b2b_accepts", 32'(acc), 32'd2);
        chk("b2b_spacing", 32'(t2 - t1), 32'(3 + WAIT_A));
        chk("b2b_ready_lo", 32'(rlo), 32'(2 + WAIT_A));
        chk("b2b_miso", 32'(miso_a), 32'h5A5A);
        chk("turnaround", 32'(n_tovr), 32'd0);

        // cs_n high blocks acceptance
        @(negedge sck);
        cs_n_a = 1'b1;
        cmd_valid_a = 1'b1;
        mosi_a = {1'b1, 16'hDEAD, 19'h00050};
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge sck);
            if (!ce_n_a || busy_a || rsp_valid_a || !cmd_ready_a) n++;
        end
        cmd_valid_a = 1'b0;
        chk("cs_block", 32'(n), 32'd0);

        // cs_n dropped during SETUP does not abort
        acc_a(1'b0, 16'h0000, 19'h00020, 1'b1, rk, nr, wl, ol, m, bd);
        chk("csdrop_rsp_lat", 32'(rk), 32'd3);
        chk("csdrop_rsp_cnt", 32'(nr), 32'd1);
        chk("csdrop_miso", 32'(miso_a), 32'hA5A5);
        chk("csdrop_pins", 32'(bd), 32'd0);

        // Async reset in the middle of a write
        @(negedge sck);
        cs_n_a = 1'b0;
        cmd_valid_a = 1'b1;
        mosi_a = {1'b1, 16'h7777, 19'h00050};
        @(posedge sck);
        #1;
        cmd_valid_a = 1'b0;
        cs_n_a = 1'b1;
        @(negedge sck);
        @(negedge sck);
        chk("mid_we_low", 32'(we_n_a), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_strobes", 32'({we_n_a, ce_n_a, ub_a, lb_a}), 32'hF);
        chk("mid_rst_dq_z", 32'(dq_a), 32'hFFFF);
        chk("mid_rst_addr", 32'(addr_a), 32'd0);
        chk("mid_rst_outs", 32'({miso_a, rsp_valid_a, busy_a}), 32'd0);
        @(negedge sck);
        #2 rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge sck);
            if (rsp_valid_a || !ce_n_a) n++;
        end
        chk("post_rst_quiet", 32'(n), 32'd0);
        chk("post_rst_ready", 32'(cmd_ready_a), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
